// File: rtl/line_double_reader_if.sv
// FIFO-side and pixel-stream signals of the line doubling reader.
// The master side is the reader itself; the slave side is its environment.
interface line_double_reader_if #(
  parameter int DATA_W = 8
) ();
  logic              full;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              empty_enable;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sol;
  logic              pix_eol;
  logic              pix_dup;

  modport master (
    input  full, rd_data, pix_ready,
    output rd_req, empty_enable, pix_data, pix_valid, pix_sol, pix_eol, pix_dup
  );

  modport slave (
    output full, rd_data, pix_ready,
    input  rd_req, empty_enable, pix_data, pix_valid, pix_sol, pix_eol, pix_dup
  );
endinterface

// File: rtl/line_double_reader.sv
// Reads each complete line from the deinterlacer FIFO twice (bob line doubling)
// and streams the words out through a 2-deep skid buffer with line markers.
module line_double_reader #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 10,
  parameter int HBLANK   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  line_double_reader_if.master bus,
  output logic                 busy,
  output logic                 underrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ0   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_READ1   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [9:0] LEN      = 10'(LINE_LEN);
  localparam logic [9:0] LAST     = 10'(LINE_LEN - 1);
  localparam logic [9:0] GAP_LAST = 10'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam bit         NO_GAP   = (HBLANK == 0);

  logic [2:0]        state, state_next;
  logic [9:0]        rd_cnt, rd_cnt_next;
  logic [9:0]        out_cnt;
  logic [9:0]        gap_cnt;
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_dup;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_next;
  logic              abort;
  logic              push, xfer, entering, req_next;

  // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      S_IDLE:
        if (bus.full) state_next = S_READ0;
      S_READ0:
        if (!bus.full) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (bus.rd_req && rd_cnt == LAST) begin
          state_next = NO_GAP ? S_READ1 : S_GAP;
        end
      S_GAP:
        if (!bus.full) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = S_READ1;
        end
      S_READ1:
        if (!bus.full) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (bus.rd_req && rd_cnt == LAST) begin
          state_next = S_RELEASE;
        end
      S_RELEASE:
        if (!bus.full) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // An in-flight word is captured at the edge that ends its rd_req cycle,
  // so the occupancy seen by the next request already includes it.
  assign xfer = bus.pix_valid & bus.pix_ready;
  assign push = bus.rd_req & ~abort;

  always_comb begin
    count_next = abort ? 2'd0 : count + {1'b0, push} - {1'b0, xfer};
    entering   = (state_next != state) &&
                 (state_next == S_READ0 || state_next == S_READ1);
    rd_cnt_next = entering ? 10'd0 : rd_cnt + {9'd0, bus.rd_req};
    req_next   = (state_next == S_READ0 || state_next == S_READ1) &&
                 (rd_cnt_next < LEN) && (count_next < 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      rd_cnt           <= '0;
      out_cnt          <= '0;
      gap_cnt          <= '0;
      count            <= '0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      buf_dup          <= '0;
      // NOTE: the two buffer entries are reset because pix_data is a visible output with a defined reset value.
      buf_data[0]      <= '0;
      buf_data[1]      <= '0;
      bus.rd_req       <= 1'b0;
      bus.empty_enable <= 1'b0;
      busy             <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      state            <= state_next;
      rd_cnt           <= rd_cnt_next;
      gap_cnt          <= (state == S_GAP && state_next == S_GAP) ? gap_cnt + 10'd1 : 10'd0;
      count            <= count_next;
      bus.rd_req       <= req_next;
      bus.empty_enable <= (state_next == S_READ1) || (state_next == S_RELEASE);
      busy             <= (state_next != S_IDLE);
      underrun         <= abort;
      if (abort) begin
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        out_cnt <= '0;
      end else begin
        if (push) begin
          buf_data[wr_ptr] <= bus.rd_data;
          buf_dup[wr_ptr]  <= (state == S_READ1);
          wr_ptr           <= ~wr_ptr;
        end
        if (xfer) begin
          rd_ptr  <= ~rd_ptr;
          out_cnt <= (out_cnt == LAST) ? 10'd0 : out_cnt + 10'd1;
        end
      end
    end
  end

  // Stream outputs depend only on buffer state, never on pix_ready.
  assign bus.pix_valid = (count != 2'd0);
  assign bus.pix_data  = buf_data[rd_ptr];
  assign bus.pix_sol   = bus.pix_valid & (out_cnt == 10'd0);
  assign bus.pix_eol   = bus.pix_valid & (out_cnt == LAST);
  assign bus.pix_dup   = bus.pix_valid & buf_dup[rd_ptr];

endmodule

// File: tb/tb_line_double_reader.sv
// Scoreboard bench for line_double_reader: a FIFO model feeds lines, expected
// pixels are queued when a line is loaded and compared on every transfer.
module tb_line_double_reader;

  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 10;
  localparam int HBLANK   = 4;

  logic clock;
  logic reset;
  logic busy, underrun;
  logic busy_ng, underrun_ng;

  line_double_reader_if #(.DATA_W(DATA_W)) bus ();
  line_double_reader_if #(.DATA_W(DATA_W)) bus_ng ();

  line_double_reader #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .HBLANK(HBLANK)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.master),
    .busy     (busy),
    .underrun (underrun)
  );

  line_double_reader #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .HBLANK(0)) dut_ng (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_ng.master),
    .busy     (busy_ng),
    .underrun (underrun_ng)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: {data, dup, sol, eol}
  logic [DATA_W+2:0] exp_q [$];
  int   req_log [$];
  bit   ee_log [$];
  int   xfer_log [$];
  int   ng_req [$];

  int          cyc = 0;
  logic [7:0]  line_base = 8'h10;
  int          ptr = 0;
  bit          line_done = 0;
  bit          bp_mode = 0;
  logic [3:0]  bp_pat = 4'b1001;
  int          occ = 0;
  int          max_occ = 0;
  int          valid_err = 0;
  int          stall_err = 0;
  bit          stall_prev = 0;
  logic [7:0]  stall_data = '0;
  int          n_underrun = 0;
  int          uflush_left = -1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // FIFO model: a registered-output line store that keeps the line while full.
  initial begin
    bus.rd_data = '0;
    forever begin
      @(posedge clock);
      #2;
      if (!bus.full) ptr = 0;
      else if (bus.rd_req) begin
        bus.rd_data = line_base + 8'(ptr % LINE_LEN);
        ptr++;
      end
      line_done = (ptr >= 2 * LINE_LEN);
    end
  end

  // Downstream ready: always 1, or the 1,0,0,1 back-pressure pattern.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.pix_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      occ        = 0;
      stall_prev = 0;
    end else begin
      if (underrun) begin
        n_underrun++;
        uflush_left = exp_q.size();
        exp_q.delete();
        occ = 0;
      end
      if (bus.pix_valid !== (occ != 0)) valid_err++;
      if (occ + int'(bus.rd_req) > max_occ) max_occ = occ + int'(bus.rd_req);
      if (stall_prev && bus.pix_valid && bus.pix_data !== stall_data) stall_err++;
      stall_prev = bus.pix_valid & ~bus.pix_ready;
      stall_data = bus.pix_data;
      if (bus.rd_req) begin
        req_log.push_back(cyc);
        ee_log.push_back(bus.empty_enable);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        xfer_log.push_back(cyc);
        if (exp_q.size() == 0) check("extra_word", 0, 1);
        else check("pix", {bus.pix_data, bus.pix_dup, bus.pix_sol, bus.pix_eol}, exp_q.pop_front());
      end
      occ = occ + int'(bus.rd_req) - int'(bus.pix_valid & bus.pix_ready);
    end
  end

  initial forever begin
    @(negedge clock);
    if (bus_ng.rd_req) ng_req.push_back(cyc);
  end

  task automatic push_line(input logic [7:0] base);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < LINE_LEN; i++)
        exp_q.push_back({8'(base + i), (p == 1), (i == 0), (i == LINE_LEN - 1)});
  endtask

  // Called at #1 after a rising edge; returns at #1 in the first IDLE cycle.
  task automatic run_line(input logic [7:0] base, input bit do_timing);
    int  idx0, xidx, start;
    bit  ok;
    idx0  = req_log.size();
    xidx  = xfer_log.size();
    line_base = base;
    push_line(base);
    bus.full = 1'b1;
    start = cyc;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clock);
      #1;
      if (line_done) begin ok = 1; break; end
    end
    check("line_timeout", ok, 1);
    bus.full = 1'b0;
    @(negedge clock);
    check("ee_before_drop", bus.empty_enable, 1);
    @(posedge clock);
    #1;
    check("ee_after_drop", bus.empty_enable, 0);
    check("busy_after_drop", busy, 0);
    check("req_count", req_log.size() - idx0, 2 * LINE_LEN);
    if (req_log.size() >= idx0 + 2 * LINE_LEN) begin
      check("first_req", req_log[idx0] - start, 1);
      if (do_timing) begin
        check("pass0_run", req_log[idx0 + 9] - req_log[idx0], LINE_LEN - 1);
        check("gap_len", req_log[idx0 + 10] - req_log[idx0 + 9], HBLANK + 1);
        check("pass1_run", req_log[idx0 + 19] - req_log[idx0 + 10], LINE_LEN - 1);
        check("ee_pass0", ee_log[idx0 + 9], 0);
        check("ee_read1", ee_log[idx0 + 10], 1);
        if (xfer_log.size() >= xidx + 2 * LINE_LEN)
          check("out_gap", xfer_log[xidx + 10] - xfer_log[xidx + 9], HBLANK + 1);
        else
          check("out_count", xfer_log.size() - xidx, 2 * LINE_LEN);
      end
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    check("drain_timeout", ok, 1);
  endtask

  initial begin
    int  idx;
    bit  ok;
    reset = 1'b0;
    bus.full = 1'b0;
    bus_ng.full = 1'b0;
    bus_ng.rd_data = 8'h5A;
    bus_ng.pix_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    check("reset_outs", {bus.rd_req, bus.empty_enable, bus.pix_valid, bus.pix_sol, bus.pix_eol,
                         bus.pix_dup, busy, underrun, bus.pix_data}, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_busy", busy, 0);

    // Basic line double with full-rate output
    run_line(8'h10, 1);
    drain();

    // Back-pressure 1,0,0,1
    bp_mode = 1;
    max_occ = 0;
    run_line(8'h10, 0);
    drain();
    bp_mode = 0;
    check("max_occ_le2", (max_occ <= 2), 1);
    check("stall_stable", stall_err, 0);
    check("valid_model", valid_err, 0);

    // No gap (HBLANK = 0 instance)
    @(posedge clock);
    #1;
    idx = ng_req.size();
    bus_ng.full = 1'b1;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clock);
      #1;
      if (ng_req.size() - idx >= 2 * LINE_LEN) begin ok = 1; break; end
    end
    check("ng_timeout", ok, 1);
    bus_ng.full = 1'b0;
    @(posedge clock);
    #1;
    check("ng_busy", busy_ng, 0);
    check("ng_req_count", ng_req.size() - idx, 2 * LINE_LEN);
    if (ng_req.size() >= idx + 2 * LINE_LEN) begin
      check("ng_gap", ng_req[idx + 10] - ng_req[idx + 9], 1);
      check("ng_pass1_run", ng_req[idx + 19] - ng_req[idx + 10], LINE_LEN - 1);
    end

    // Underrun after 5 pass-0 reads
    @(posedge clock);
    #1;
    idx = req_log.size();
    line_base = 8'h10;
    push_line(8'h10);
    bus.full = 1'b1;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (req_log.size() - idx >= 5) begin ok = 1; break; end
    end
    check("ur_wait", ok, 1);
    bus.full = 1'b0;
    @(posedge clock);
    #1;
    check("ur_pulse", underrun, 1);
    check("ur_valid", bus.pix_valid, 0);
    check("ur_busy", busy, 0);
    check("ur_rd_req", bus.rd_req, 0);
    @(posedge clock);
    #1;
    check("ur_pulse_end", underrun, 0);
    check("ur_words_out", uflush_left, 2 * LINE_LEN - 4);
    run_line(8'h10, 1);
    drain();

    // Asynchronous reset in READ1
    @(posedge clock);
    #1;
    line_base = 8'h50;
    push_line(8'h50);
    bus.full = 1'b1;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clock);
      #1;
      if (bus.empty_enable) begin ok = 1; break; end
    end
    check("read1_wait", ok, 1);
    reset = 1'b1;
    bus.full = 1'b0;
    #1;
    check("async_reset_outs", {bus.rd_req, bus.empty_enable, bus.pix_valid, bus.pix_sol, bus.pix_eol,
                               bus.pix_dup, busy, underrun, bus.pix_data}, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Three back-to-back lines
    run_line(8'h20, 1);
    run_line(8'h30, 1);
    run_line(8'h40, 1);
    drain();

    check("underrun_total", n_underrun, 1);
    check("valid_model_end", valid_err, 0);
    check("stall_stable_end", stall_err, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
